// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store controller in front of data_memory: one response per accepted request.
// Optional one-entry posted store buffer under `MEM_ACCESS_CTRL_STORE_BUFFER_EN.
module mem_access_ctrl #(
  parameter int MEM_DEPTH = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        d_mem_write_en,
  output logic        d_mem_read,
  output logic [15:0] d_mem_addr,
  output logic [15:0] d_mem_write_data,
  input  logic [15:0] d_mem_read_data
);

  typedef enum logic [1:0] {IDLE, RD, WR, RSP} state_t;

  localparam logic [16:0] DEPTH = 17'(MEM_DEPTH);

  state_t      state;
  logic [15:0] addr_q;
  logic        in_range;
  logic        rd_en;

  assign in_range  = {1'b0, req_addr} < DEPTH;
  assign req_ready = (state == IDLE) && !rst;
  assign rd_en     = !rst && (state == RD);
  assign d_mem_read = rd_en;

`ifdef MEM_ACCESS_CTRL_STORE_BUFFER_EN
  logic        sb_valid;
  logic [15:0] sb_addr, sb_data;
  logic        drain, sb_hit;

  // The entry survives its own response cycle so a load issued right behind the
  // store can still be forwarded; it is written out in the following IDLE cycle.
  assign drain  = !rst && sb_valid && (state == IDLE);
  assign sb_hit = sb_valid && (sb_addr == req_addr);

  assign d_mem_write_en   = drain;
  assign d_mem_addr       = rd_en ? addr_q : (drain ? sb_addr : 16'h0);
  assign d_mem_write_data = drain ? sb_data : 16'h0;
`else
  logic [15:0] wdata_q;
  logic        wr_en;

  assign wr_en            = !rst && (state == WR);
  assign d_mem_write_en   = wr_en;
  assign d_mem_addr       = (rd_en || wr_en) ? addr_q : 16'h0;
  assign d_mem_write_data = wr_en ? wdata_q : 16'h0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      addr_q    <= 16'h0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= 16'h0;
`ifdef MEM_ACCESS_CTRL_STORE_BUFFER_EN
      sb_valid  <= 1'b0;
      sb_addr   <= 16'h0;
      sb_data   <= 16'h0;
`else
      wdata_q   <= 16'h0;
`endif
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= 16'h0;
`ifdef MEM_ACCESS_CTRL_STORE_BUFFER_EN
      if (drain) sb_valid <= 1'b0;
`endif
      case (state)
        IDLE: if (req_valid) begin
          if (!in_range) begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            state     <= RSP;
          end else if (req_we) begin
`ifdef MEM_ACCESS_CTRL_STORE_BUFFER_EN
            // a same-edge drain has already written the old entry
            sb_valid  <= 1'b1;
            sb_addr   <= req_addr;
            sb_data   <= req_wdata;
            rsp_valid <= 1'b1;
            state     <= RSP;
`else
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            state     <= WR;
`endif
          end else begin
`ifdef MEM_ACCESS_CTRL_STORE_BUFFER_EN
            if (sb_hit) begin
              rsp_valid <= 1'b1;
              rsp_rdata <= sb_data;
              state     <= RSP;
            end else begin
              addr_q <= req_addr;
              state  <= RD;
            end
`else
            addr_q <= req_addr;
            state  <= RD;
`endif
          end
        end
        RD: begin
          rsp_valid <= 1'b1;
          rsp_rdata <= d_mem_read_data;
          state     <= RSP;
        end
        WR: begin
          rsp_valid <= 1'b1;
          state     <= RSP;
        end
        RSP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed scenarios plus a randomized run against an array model.
module tb_mem_access_ctrl;
  logic        clk = 1'b0;
  logic        rst, req_valid, req_we;
  logic [15:0] req_addr, req_wdata;
  logic        req_ready, rsp_valid, rsp_err;
  logic [15:0] rsp_rdata;
  logic        d_mem_write_en, d_mem_read;
  logic [15:0] d_mem_addr, d_mem_write_data, d_mem_read_data;

  mem_access_ctrl #(.MEM_DEPTH(256)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .d_mem_write_en(d_mem_write_en), .d_mem_read(d_mem_read),
    .d_mem_addr(d_mem_addr), .d_mem_write_data(d_mem_write_data),
    .d_mem_read_data(d_mem_read_data)
  );

  always #5 clk = ~clk;

`ifdef MEM_ACCESS_CTRL_STORE_BUFFER_EN
  localparam bit BUF = 1'b1;
`else
  localparam bit BUF = 1'b0;
`endif

  logic [15:0] ram     [0:255];
  logic [15:0] ref_mem [0:255];
  assign d_mem_read_data = d_mem_read ? ram[d_mem_addr[7:0]] : 16'h0;
  always @(posedge clk) if (d_mem_write_en) ram[d_mem_addr[7:0]] <= d_mem_write_data;

  int checks = 0, errors = 0;
  int rd_cnt = 0, wr_cnt = 0, overlap = 0, idle_bad = 0;
  logic mon_en = 1'b0;
  logic [15:0] last_wa, last_wd;
  always @(negedge clk) if (mon_en) begin
    if (d_mem_read) rd_cnt++;
    if (d_mem_write_en) begin wr_cnt++; last_wa = d_mem_addr; last_wd = d_mem_write_data; end
    if (d_mem_read && d_mem_write_en) overlap++;
    if (!d_mem_read && !d_mem_write_en && (d_mem_addr != 16'h0 || d_mem_write_data != 16'h0)) idle_bad++;
  end

  int   cyc = 0;
  logic acc_flag = 1'b0;
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    acc_flag <= req_valid && req_ready;
  end

  // Drives one request, waits for acceptance, then returns the response seen.
  task automatic issue(input logic we, input logic [15:0] a, input logic [15:0] d,
                       output int lat, output logic [15:0] rd, output logic er, output int acyc);
    lat = -1; rd = 16'h0; er = 1'b0; acyc = -1;
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (acc_flag) begin acyc = cyc; break; end
    end
    req_valid = 1'b0; req_we = 1'b0; req_addr = 16'h0; req_wdata = 16'h0;
    if (acyc >= 0)
      for (int k = 1; k <= 5; k++) begin
        @(negedge clk);
        if (rsp_valid) begin lat = k; rd = rsp_rdata; er = rsp_err; break; end
      end
  endtask

  task automatic test_reset;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 16'h0; req_wdata = 16'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    mon_en = 1'b1;
    checks++;
    if ({req_ready, rsp_valid, rsp_err, rsp_rdata, d_mem_read, d_mem_write_en, d_mem_addr, d_mem_write_data} !== 52'h0) begin
      errors++; $display("FAIL reset_hold ready=%b rv=%b re=%b rd=%h mr=%b mw=%b ma=%h md=%h exp all 0",
        req_ready, rsp_valid, rsp_err, rsp_rdata, d_mem_read, d_mem_write_en, d_mem_addr, d_mem_write_data);
    end
    rst = 1'b0; #1;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || d_mem_read !== 1'b0 || d_mem_write_en !== 1'b0 || d_mem_addr !== 16'h0) begin
      errors++; $display("FAIL reset_release ready=%b rv=%b mr=%b mw=%b ma=%h exp ready=1 rest 0",
        req_ready, rsp_valid, d_mem_read, d_mem_write_en, d_mem_addr);
    end
  endtask

  task automatic test_load3;
    int r0 = rd_cnt;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 16'd3;
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = 16'h0;
    checks++;
    if (acc_flag !== 1'b1) begin errors++; $display("FAIL load3_accept got %b exp 1", acc_flag); end
    @(negedge clk);
    checks++;
    if (d_mem_read !== 1'b1 || d_mem_addr !== 16'd3 || d_mem_write_en !== 1'b0 || req_ready !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL load3_rd mr=%b ma=%h mw=%b ready=%b rv=%b exp 1 3 0 0 0",
        d_mem_read, d_mem_addr, d_mem_write_en, req_ready, rsp_valid);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 16'd3 || rsp_err !== 1'b0 || req_ready !== 1'b0 || d_mem_read !== 1'b0) begin
      errors++; $display("FAIL load3_rsp rv=%b rd=%h re=%b ready=%b mr=%b exp 1 3 0 0 0",
        rsp_valid, rsp_rdata, rsp_err, req_ready, d_mem_read);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rd_cnt - r0 != 1) begin
      errors++; $display("FAIL load3_after rv=%b ready=%b reads=%0d exp 0 1 1", rsp_valid, req_ready, rd_cnt - r0);
    end
  endtask

  task automatic test_store_load;
    int lat, ac, w0 = wr_cnt;
    logic [15:0] rd; logic er;
    issue(1'b1, 16'd7, 16'h0000, lat, rd, er, ac);
    checks++;
    if (lat != (BUF ? 1 : 2) || rd !== 16'h0 || er !== 1'b0) begin
      errors++; $display("FAIL store7 lat=%0d rd=%h err=%b exp lat=%0d rd=0 err=0", lat, rd, er, BUF ? 1 : 2);
    end
    ref_mem[7] = 16'h0;
    repeat (2) @(negedge clk);
    checks++;
    if (wr_cnt - w0 != 1 || last_wa !== 16'd7 || last_wd !== 16'h0) begin
      errors++; $display("FAIL store7_write n=%0d addr=%h data=%h exp 1 7 0", wr_cnt - w0, last_wa, last_wd);
    end
    issue(1'b0, 16'd7, 16'h0, lat, rd, er, ac);
    checks++;
    if (lat != 2 || rd !== 16'h0 || er !== 1'b0) begin
      errors++; $display("FAIL load7 lat=%0d rd=%h err=%b exp 2 0 0", lat, rd, er);
    end
    issue(1'b0, 16'd5, 16'h0, lat, rd, er, ac);
    checks++;
    if (lat != 2 || rd !== 16'd5 || er !== 1'b0) begin
      errors++; $display("FAIL load5 lat=%0d rd=%h err=%b exp 2 5 0", lat, rd, er);
    end
  endtask

  task automatic test_error;
    int lat, ac, r0 = rd_cnt, w0 = wr_cnt;
    logic [15:0] rd; logic er;
    issue(1'b0, 16'd300, 16'h0, lat, rd, er, ac);
    checks++;
    if (lat != 1 || rd !== 16'h0 || er !== 1'b1) begin
      errors++; $display("FAIL err_load300 lat=%0d rd=%h err=%b exp 1 0 1", lat, rd, er);
    end
    issue(1'b1, 16'hFFFF, 16'hBEEF, lat, rd, er, ac);
    checks++;
    if (lat != 1 || rd !== 16'h0 || er !== 1'b1) begin
      errors++; $display("FAIL err_storeFFFF lat=%0d rd=%h err=%b exp 1 0 1", lat, rd, er);
    end
    issue(1'b0, 16'd256, 16'h0, lat, rd, er, ac);
    checks++;
    if (lat != 1 || er !== 1'b1) begin
      errors++; $display("FAIL err_load256 lat=%0d err=%b exp 1 1", lat, er);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (rd_cnt != r0 || wr_cnt != w0) begin
      errors++; $display("FAIL err_no_access reads=%0d writes=%0d exp 0 0", rd_cnt - r0, wr_cnt - w0);
    end
  endtask

  task automatic test_reset_rd;
    int seen = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 16'd4;
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = 16'h0;
    rst = 1'b1;
    @(negedge clk);
    if (rsp_valid) seen++;
    @(negedge clk);
    checks++;
    if ({rsp_valid, rsp_err, rsp_rdata, d_mem_read, d_mem_write_en, d_mem_addr, d_mem_write_data} !== 51'h0) begin
      errors++; $display("FAIL rst_rd_outputs rv=%b re=%b rd=%h mr=%b mw=%b ma=%h md=%h exp all 0",
        rsp_valid, rsp_err, rsp_rdata, d_mem_read, d_mem_write_en, d_mem_addr, d_mem_write_data);
    end
    rst = 1'b0; #1;
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_rd_ready got %b exp 1", req_ready); end
    repeat (3) begin @(negedge clk); if (rsp_valid) seen++; end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL rst_rd_no_rsp got %0d pulses exp 0", seen); end
  endtask

  task automatic test_store_buffer;
    int lat, ac, r0, w0;
    logic [15:0] rd; logic er;
    r0 = rd_cnt; w0 = wr_cnt;
    issue(1'b1, 16'd9, 16'h1234, lat, rd, er, ac);
    issue(1'b0, 16'd9, 16'h0, lat, rd, er, ac);
    ref_mem[9] = 16'h1234;
    checks++;
    if (lat != 1 || rd !== 16'h1234 || er !== 1'b0 || rd_cnt != r0) begin
      errors++; $display("FAIL sb_forward lat=%0d rd=%h err=%b reads=%0d exp 1 1234 0 0", lat, rd, er, rd_cnt - r0);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (wr_cnt - w0 != 1 || last_wa !== 16'd9 || last_wd !== 16'h1234) begin
      errors++; $display("FAIL sb_drain n=%0d addr=%h data=%h exp 1 9 1234", wr_cnt - w0, last_wa, last_wd);
    end
    issue(1'b0, 16'd9, 16'h0, lat, rd, er, ac);
    checks++;
    if (lat != 2 || rd !== 16'h1234 || rd_cnt - r0 != 1) begin
      errors++; $display("FAIL sb_mem_load lat=%0d rd=%h reads=%0d exp 2 1234 1", lat, rd, rd_cnt - r0);
    end
    w0 = wr_cnt;
    issue(1'b1, 16'd10, 16'h7777, lat, rd, er, ac);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (wr_cnt != w0) begin errors++; $display("FAIL sb_reset_discard writes=%0d exp 0", wr_cnt - w0); end
    issue(1'b0, 16'd10, 16'h0, lat, rd, er, ac);
    checks++;
    if (rd !== ref_mem[10]) begin errors++; $display("FAIL sb_reset_load10 got %h exp %h", rd, ref_mem[10]); end
  endtask

  task automatic test_back_to_back;
    int lat, ac;
    logic [15:0] rd; logic er;
    issue(1'b1, 16'd1, 16'hAAAA, lat, rd, er, ac);
    issue(1'b1, 16'd2, 16'h5555, lat, rd, er, ac);
    ref_mem[1] = 16'hAAAA; ref_mem[2] = 16'h5555;
    issue(1'b0, 16'd1, 16'h0, lat, rd, er, ac);
    checks++;
    if (rd !== 16'hAAAA || er !== 1'b0) begin errors++; $display("FAIL b2b_load1 got %h err=%b exp aaaa 0", rd, er); end
    issue(1'b0, 16'd2, 16'h0, lat, rd, er, ac);
    checks++;
    if (rd !== 16'h5555 || er !== 1'b0) begin errors++; $display("FAIL b2b_load2 got %h err=%b exp 5555 0", rd, er); end
  endtask

  task automatic test_random;
    int lat, ac, r0, w0, exp_rd_n = 0, exp_wr_n = 0, exp_lat;
    int ls_cyc = -10; logic [15:0] ls_addr = 16'h0; logic ls_valid = 1'b0;
    logic [15:0] rd, a, d, exp_rdata; logic er, we, exp_err, hit;
    r0 = rd_cnt; w0 = wr_cnt;
    for (int n = 0; n < 80; n++) begin
      we = $urandom_range(0, 1) == 1;
      a  = ($urandom_range(0, 5) == 0) ? 16'($urandom_range(256, 65535)) : 16'($urandom_range(0, 31));
      d  = 16'($urandom);
      if (!we && ls_valid && $urandom_range(0, 3) == 0) a = ls_addr;
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 2)) @(negedge clk);
      issue(we, a, d, lat, rd, er, ac);
      exp_err = a >= 16'd256;
      hit = BUF && !we && ls_valid && a == ls_addr && ac == ls_cyc + 2;
      exp_rdata = (exp_err || we) ? 16'h0 : ref_mem[a[7:0]];
      exp_lat = (exp_err || hit || (BUF && we)) ? 1 : 2;
      if (!exp_err && we) begin
        ref_mem[a[7:0]] = d; exp_wr_n++;
        ls_valid = 1'b1; ls_addr = a; ls_cyc = ac;
      end
      if (!exp_err && !we && !hit) exp_rd_n++;
      checks++;
      if (lat != exp_lat || rd !== exp_rdata || er !== exp_err) begin
        errors++; $display("FAIL rand_%0d we=%b a=%h lat=%0d rd=%h err=%b exp lat=%0d rd=%h err=%b",
          n, we, a, lat, rd, er, exp_lat, exp_rdata, exp_err);
      end
    end
    repeat (4) @(negedge clk);
    checks++;
    if (rd_cnt - r0 != exp_rd_n || wr_cnt - w0 != exp_wr_n) begin
      errors++; $display("FAIL rand_access_counts reads=%0d writes=%0d exp %0d %0d",
        rd_cnt - r0, wr_cnt - w0, exp_rd_n, exp_wr_n);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin ram[i] = 16'(i); ref_mem[i] = 16'(i); end
    test_reset();
    test_load3();
    test_store_load();
    test_error();
    test_reset_rd();
    if (BUF) test_store_buffer();
    test_back_to_back();
    test_random();
    checks++;
    if (overlap != 0) begin errors++; $display("FAIL rd_wr_overlap got %0d cycles exp 0", overlap); end
    checks++;
    if (idle_bad != 0) begin errors++; $display("FAIL idle_nonzero got %0d cycles exp 0", idle_bad); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
